// File: rtl/secam_pkg.sv
// ============================================================================
//  Package     : secam_pkg
//  Description : Shared state type and default line-timing constants for the
//                SECAM line sequencer and its testbench.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package secam_pkg;

    // Default intra-line timing, in clocks counted from line_start
    localparam int c_CNT_W        = 12;
    localparam int c_REF_START    = 480;
    localparam int c_ACTIVE_START = 720;
    localparam int c_ACTIVE_END   = 3000;
    localparam int c_CARRIER_END  = 3050;

    // Carrier phases within one line
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        REF    = 2'd1,
        ACTIVE = 2'd2,
        TAIL   = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/secam_line_sequencer_if.sv
// ============================================================================
//  Interface   : secam_line_sequencer_if
//  Description : Line-timing inputs, chroma inputs and encoder-control outputs
//                of the SECAM line sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface secam_line_sequencer_if;

    logic              line_start;
    logic              newframe;
    logic              video_line;
    logic              db_first;
    logic              seq_enable;
    logic signed [7:0] yuv_u_in;
    logic signed [7:0] yuv_v_in;
    logic              even_line;
    logic              enabled;
    logic signed [7:0] yuv_u;
    logic signed [7:0] yuv_v;
    logic              active;

    // Timing generator / stimulus side
    modport master (
        output line_start, newframe, video_line, db_first, seq_enable,
        output yuv_u_in, yuv_v_in,
        input  even_line, enabled, yuv_u, yuv_v, active
    );

    // Sequencer side
    modport slave (
        input  line_start, newframe, video_line, db_first, seq_enable,
        input  yuv_u_in, yuv_v_in,
        output even_line, enabled, yuv_u, yuv_v, active
    );

endinterface

`default_nettype wire

// File: rtl/secam_line_counter.sv
// ============================================================================
//  Module      : secam_line_counter
//  Description : Intra-line clock counter. Cleared by line_start, saturates
//                at all-ones when line_start goes missing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module secam_line_counter #(
    parameter int CNT_W = 12
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    output logic [CNT_W-1:0]      o_count
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Clear on line_start, else count up and hold at the maximum (no wrap)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != c_MAX) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/secam_line_sequencer.sv
// ============================================================================
//  Module      : secam_line_sequencer
//  Description : Per-line controller for the SECAM chroma encoder. Produces
//                the Db/Dr alternation, the carrier enable window and the
//                reference-carrier intervals around active video.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module secam_line_sequencer
    import secam_pkg::*;
#(
    parameter int CNT_W        = c_CNT_W,
    parameter int REF_START    = c_REF_START,
    parameter int ACTIVE_START = c_ACTIVE_START,
    parameter int ACTIVE_END   = c_ACTIVE_END,
    parameter int CARRIER_END  = c_CARRIER_END
) (
    input  wire logic               clk,
    input  wire logic               rst,
    secam_line_sequencer_if.slave   bus
);

    // Timing points resized to the counter width so every compare is unsigned
    localparam logic [CNT_W-1:0] c_REF_AT    = CNT_W'(REF_START);
    localparam logic [CNT_W-1:0] c_ACT_AT    = CNT_W'(ACTIVE_START);
    localparam logic [CNT_W-1:0] c_TAIL_AT   = CNT_W'(ACTIVE_END);
    localparam logic [CNT_W-1:0] c_OFF_AT    = CNT_W'(CARRIER_END);
    localparam longint           c_CNT_MAX   = (64'd1 << CNT_W) - 64'd1;

    // Timing points must be strictly increasing and below the saturation value
    generate
        if (!((REF_START < ACTIVE_START) && (ACTIVE_START < ACTIVE_END) &&
              (ACTIVE_END < CARRIER_END) && (longint'(CARRIER_END) < c_CNT_MAX))) begin : g_bad_timing
            $error("secam_line_sequencer: timing parameters out of order");
        end
    endgenerate

    logic [CNT_W-1:0]  w_count;
    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic              r_line_ok;
    logic              r_even_line;
    logic              r_enabled;
    logic              r_active;
    logic signed [7:0] r_yuv_u;
    logic signed [7:0] r_yuv_v;

    secam_line_counter #(
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.line_start),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state from the counter position; line_start aborts any line
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            OFF:     if (r_line_ok && (w_count == c_REF_AT)) w_state_next = REF;
            REF:     if (w_count == c_ACT_AT)                w_state_next = ACTIVE;
            ACTIVE:  if (w_count == c_TAIL_AT)               w_state_next = TAIL;
            TAIL:    if (w_count == c_OFF_AT)                w_state_next = OFF;
            default:                                         w_state_next = OFF;
        endcase
        if (bus.line_start) begin
            w_state_next = OFF;
        end
    end

    // Line qualification, sampled only at the line boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_ok <= 1'b0;
        end else if (bus.line_start) begin
            r_line_ok <= bus.video_line & bus.seq_enable;
        end
    end

    // Db/Dr alternation: a frame load overrides the per-line toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_even_line <= 1'b1;
        end else if (bus.newframe) begin
            r_even_line <= bus.db_first;
        end else if (bus.line_start) begin
            r_even_line <= ~r_even_line;
        end
    end

    // Encoder controls, registered from the next state (one cycle after the match)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enabled <= 1'b0;
            r_active  <= 1'b0;
            r_yuv_u   <= '0;
            r_yuv_v   <= '0;
        end else begin
            r_enabled <= (w_state_next != OFF);
            r_active  <= (w_state_next == ACTIVE);
            r_yuv_u   <= (w_state_next == ACTIVE) ? bus.yuv_u_in : 8'sd0;
            r_yuv_v   <= (w_state_next == ACTIVE) ? bus.yuv_v_in : 8'sd0;
        end
    end

    assign bus.even_line = r_even_line;
    assign bus.enabled   = r_enabled;
    assign bus.active    = r_active;
    assign bus.yuv_u     = r_yuv_u;
    assign bus.yuv_v     = r_yuv_v;

endmodule

`default_nettype wire

// File: tb/tb_secam_line_sequencer.sv
// ============================================================================
//  Module      : tb_secam_line_sequencer
//  Description : Self-checking bench for secam_line_sequencer with a
//                line-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_secam_line_sequencer;
    import secam_pkg::*;

    localparam int c_SAT = (1 << c_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secam_line_sequencer_if bus();

    secam_line_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position within the line, line qualification, parity
    int         m_p    = 0;
    bit         m_ok   = 1'b0;
    bit         m_even = 1'b1;
    logic [7:0] m_u    = 8'd0;
    logic [7:0] m_v    = 8'd0;

    // Current level-type inputs
    bit g_vl  = 1'b0;
    bit g_se  = 1'b0;
    bit g_dbf = 1'b1;

    function automatic logic [18:0] exp_vec();
        bit en;
        bit act;
        en  = m_ok && (m_p > c_REF_START)    && (m_p <= c_CARRIER_END);
        act = m_ok && (m_p > c_ACTIVE_START) && (m_p <= c_ACTIVE_END);
        return {m_even, en, act, act ? m_u : 8'd0, act ? m_v : 8'd0};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {bus.even_line, bus.enabled, bus.active, bus.yuv_u, bus.yuv_v};
    endfunction

    task automatic model_reset();
        m_p = 0; m_ok = 1'b0; m_even = 1'b1; m_u = 8'd0; m_v = 8'd0;
    endtask

    // One clock: drive inputs, advance across the edge, update model, settle
    task automatic cyc(input bit ls, input bit nf, input logic [7:0] u, input logic [7:0] v);
        bus.line_start = ls;
        bus.newframe   = nf;
        bus.video_line = g_vl;
        bus.seq_enable = g_se;
        bus.db_first   = g_dbf;
        bus.yuv_u_in   = u;
        bus.yuv_v_in   = v;
        @(posedge clk);
        if (ls) begin
            m_p    = 0;
            m_ok   = g_vl && g_se;
            m_even = nf ? g_dbf : ~m_even;
        end else begin
            if (m_p < c_SAT) m_p++;
            if (nf) m_even = g_dbf;
        end
        m_u = u;
        m_v = v;
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] o;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        o = obs_vec();
        n_checks++;
        if (o !== 19'h40000) $display("FAIL reset_init got %h want %h", o, 19'h40000);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        g_vl = 1'b1; g_se = 1'b1;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL reset_pre p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (bus.active !== 1'b1) $display("FAIL reset_in_active got %b want 1", bus.active);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        o = obs_vec();
        n_checks++;
        if (o !== 19'h40000) $display("FAIL reset_async got %h want %h", o, 19'h40000);
        else n_pass++;
        @(posedge clk); #1;
        o = obs_vec();
        n_checks++;
        if (o !== 19'h40000) $display("FAIL reset_held got %h want %h", o, 19'h40000);
        else n_pass++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_normal_line();
        g_vl = 1'b1; g_se = 1'b1;
        cyc(1'b1, 1'b0, 8'd25, 8'($urandom));
        for (int i = 0; i < 3200; i++) begin
            cyc(1'b0, 1'b0, 8'd25, 8'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL normal p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
            if (m_p == 480 || m_p == 481 || m_p == 3050 || m_p == 3051) begin
                n_checks++;
                if (bus.enabled !== (m_p == 481 || m_p == 3050))
                    $display("FAIL normal_enable_edge p=%0d got %b", m_p, bus.enabled);
                else n_pass++;
            end
            if (m_p == 720 || m_p == 721 || m_p == 3000 || m_p == 3001) begin
                n_checks++;
                if ({bus.active, bus.yuv_u} !== ((m_p == 721 || m_p == 3000) ? 9'h119 : 9'h000))
                    $display("FAIL normal_active_edge p=%0d got %b/%0d", m_p, bus.active, bus.yuv_u);
                else n_pass++;
            end
        end
    endtask

    task automatic test_alternation();
        bit want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        g_vl = 1'b1; g_se = 1'b1; g_dbf = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, (k == 0), 8'($urandom), 8'($urandom));
            n_checks++;
            if (bus.even_line !== want[k]) $display("FAIL alt_line%0d got %b want %b", k, bus.even_line, want[k]);
            else n_pass++;
            for (int i = 0; i < 10; i++) begin
                cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL alt p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
                else n_pass++;
            end
        end
        g_dbf = 1'b0;
        cyc(1'b1, 1'b1, 8'($urandom), 8'($urandom));
        n_checks++;
        if (bus.even_line !== 1'b0) $display("FAIL alt_frame_load got %b want 0", bus.even_line);
        else n_pass++;
        // frame load without a line boundary, then a normal toggle
        g_dbf = 1'b1;
        cyc(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        n_checks++;
        if (bus.even_line !== 1'b1) $display("FAIL alt_load_midline got %b want 1", bus.even_line);
        else n_pass++;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        n_checks++;
        if (bus.even_line !== 1'b0) $display("FAIL alt_after_load got %b want 0", bus.even_line);
        else n_pass++;
    endtask

    task automatic test_non_video();
        bit prev;
        prev = m_even;
        g_vl = 1'b0; g_se = 1'b1;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        n_checks++;
        if (bus.even_line !== ~prev) $display("FAIL nonvideo_toggle got %b want %b", bus.even_line, ~prev);
        else n_pass++;
        for (int i = 0; i < 3200; i++) begin
            cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if (bus.enabled !== 1'b0 || obs_vec() !== exp_vec())
                $display("FAIL nonvideo p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        g_vl = 1'b1; g_se = 1'b1;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 1500; i++) cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
        n_checks++;
        if (bus.active !== 1'b1) $display("FAIL abort_pre got %b want 1", bus.active);
        else n_pass++;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        n_checks++;
        if ({bus.enabled, bus.active, bus.yuv_u} !== 10'd0)
            $display("FAIL abort_cut got %b want 0", {bus.enabled, bus.active, bus.yuv_u});
        else n_pass++;
        for (int i = 0; i < 3100; i++) begin
            cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL abort_next p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        g_vl = 1'b1; g_se = 1'b1;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 5000; i++) begin
            cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL sat p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (dut.u_cnt.o_count !== 12'hFFF || dut.r_state !== OFF || bus.enabled !== 1'b0)
            $display("FAIL sat_hold got cnt=%0d en=%b want cnt=4095 en=0", dut.u_cnt.o_count, bus.enabled);
        else n_pass++;
    endtask

    task automatic test_seq_disable();
        g_vl = 1'b1; g_se = 1'b1;
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 3200; i++) begin
            if (i == 1000) g_se = 1'b0;
            cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL seqdis_cur p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
            if (m_p == 2000) begin
                n_checks++;
                if (bus.active !== 1'b1) $display("FAIL seqdis_finish got %b want 1", bus.active);
                else n_pass++;
            end
        end
        cyc(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 3200; i++) begin
            cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            n_checks++;
            if (bus.enabled !== 1'b0 || obs_vec() !== exp_vec())
                $display("FAIL seqdis_next p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random_lines();
        int len;
        for (int k = 0; k < 6; k++) begin
            g_vl  = 1'($urandom);
            g_se  = ($urandom_range(0, 3) != 0);
            g_dbf = 1'($urandom);
            len   = $urandom_range(200, 3300);
            cyc(1'b1, ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom));
            for (int i = 0; i < len; i++) begin
                cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom));
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL random p=%0d got %h want %h", m_p, obs_vec(), exp_vec());
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.line_start = 1'b0;
        bus.newframe   = 1'b0;
        bus.video_line = 1'b0;
        bus.seq_enable = 1'b0;
        bus.db_first   = 1'b1;
        bus.yuv_u_in   = 8'sd0;
        bus.yuv_v_in   = 8'sd0;
        test_reset();
        test_normal_line();
        test_alternation();
        test_non_video();
        test_abort();
        test_saturation();
        test_seq_disable();
        test_random_lines();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
